// File: rtl/floating_point_divider.sv
// Iterative IEEE-754 single-precision divider (result = a / b).
// Restoring division of the 24-bit significands, one quotient bit per cycle,
// truncating (round toward zero). Denormal inputs are treated as zero.
module floating_point_divider #(
  parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        div_by_zero
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned Q_W    = 25;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned SEXP_W = 10;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(Q_W - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]         cnt;
  logic [Q_W-1:0]           q;
  logic [Q_W-1:0]           rem;
  logic [MANT_W-1:0]        divisor;
  logic signed [SEXP_W-1:0] exp_q;
  logic                     sign_q;

  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic a_zero, b_zero, a_max, b_max, a_inf, b_inf, a_nan, b_nan;
  logic accept, special, sp_sign, sp_dbz;
  logic [31:0] sp_result;
  logic signed [SEXP_W-1:0] exp_in, exp_norm;
  logic [FRAC_W-1:0] frac_norm;
  logic [31:0] norm_result;
  logic rem_ge;
  logic [MANT_W-1:0] rem_sub;

  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];

  // Operand classification and special-case result for the accept cycle
  always_comb begin
    a_zero    = (ea == '0);
    b_zero    = (eb == '0);
    a_max     = (ea == '1);
    b_max     = (eb == '1);
    a_inf     = a_max && (fa == '0);
    b_inf     = b_max && (fb == '0);
    a_nan     = a_max && (fa != '0);
    b_nan     = b_max && (fb != '0);
    accept    = in_valid && in_ready;
    special   = a_zero || b_zero || a_max || b_max;
    sp_sign   = a[31] ^ b[31];
    exp_in    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    sp_result = {sp_sign, 31'd0};
    sp_dbz    = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_result = NAN_VALUE;
    end else if (b_zero && !a_inf) begin
      sp_result = {sp_sign, 8'hFF, 23'd0};
      sp_dbz    = 1'b1;
    end else if (a_inf) begin
      sp_result = {sp_sign, 8'hFF, 23'd0};
    end
  end

  // Restoring-division step and final normalisation/packing
  always_comb begin
    rem_ge    = (rem >= {1'b0, divisor});
    rem_sub   = MANT_W'(rem - {1'b0, divisor});
    exp_norm  = q[Q_W-1] ? exp_q : exp_q - 10'sd1;
    frac_norm = q[Q_W-1] ? q[23:1] : q[22:0];
    if (exp_norm >= 10'sd255) begin
      norm_result = {sign_q, 8'hFF, 23'd0};
    end else if (exp_norm <= 10'sd0) begin
      norm_result = {sign_q, 31'd0};
    end else begin
      norm_result = {sign_q, exp_norm[7:0], frac_norm};
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = special ? DONE : DIVIDE;
      DIVIDE:  if (cnt == LAST_CNT) next_state = NORM;
      NORM:    next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered handshake outputs follow the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
    end
  end

  // Operand capture, iterative quotient generation and result write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      q           <= '0;
      rem         <= '0;
      divisor     <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_q      <= sp_sign;
          exp_q       <= exp_in;
          rem         <= {2'b01, fa};
          divisor     <= {1'b1, fb};
          q           <= '0;
          cnt         <= '0;
          div_by_zero <= special ? sp_dbz : 1'b0;
          if (special) result <= sp_result;
        end
        DIVIDE: begin
          cnt <= cnt + CNT_W'(1);
          if (rem_ge) begin
            q   <= {q[Q_W-2:0], 1'b1};
            rem <= {rem_sub, 1'b0};
          end else begin
            q   <= {q[Q_W-2:0], 1'b0};
            rem <= {rem[Q_W-2:0], 1'b0};
          end
        end
        NORM:    result <= norm_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_floating_point_divider.sv
// Self-checking bench for floating_point_divider: directed spec vectors,
// special cases, backpressure, mid-divide reset and randomized operands.
module tb_floating_point_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  floating_point_divider dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: exact integer quotient of the significands, truncated
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic d,
                                  output int lat);
    logic [7:0] ex, ey;
    logic s, xz, yz, xi, yi, xn, yn;
    longint num, den, qq;
    int e;
    logic [22:0] fr;
    ex = x[30:23]; ey = y[30:23];
    s  = x[31] ^ y[31];
    xz = (ex == 8'd0); yz = (ey == 8'd0);
    xi = (ex == 8'hFF) && (x[22:0] == 23'd0);
    yi = (ey == 8'hFF) && (y[22:0] == 23'd0);
    xn = (ex == 8'hFF) && (x[22:0] != 23'd0);
    yn = (ey == 8'hFF) && (y[22:0] != 23'd0);
    d = 1'b0;
    lat = (xz || yz || ex == 8'hFF || ey == 8'hFF) ? 0 : 26;
    if (xn || yn || (xz && yz) || (xi && yi)) r = QNAN;
    else if (yz && !xi) begin r = {s, 8'hFF, 23'd0}; d = 1'b1; end
    else if (xi) r = {s, 8'hFF, 23'd0};
    else if (yi || xz) r = {s, 31'd0};
    else begin
      num = longint'({1'b1, x[22:0]}) << 24;
      den = longint'({1'b1, y[22:0]});
      qq  = num / den;
      e   = int'(ex) - int'(ey) + 127;
      if (qq >= (64'sd1 << 24)) fr = 23'((qq >> 1) & 64'h7FFFFF);
      else begin fr = 23'(qq & 64'h7FFFFF); e = e - 1; end
      if (e >= 255)    r = {s, 8'hFF, 23'd0};
      else if (e <= 0) r = {s, 31'd0};
      else             r = {s, 8'(e), fr};
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    int k;
    logic [7:0] e;
    logic [22:0] f;
    k = $urandom_range(0, 15);
    f = 23'($urandom);
    if (k == 0) e = 8'd0;
    else if (k == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = 23'd0; end
    else e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, f};
  endfunction

  // Drives one operand pair; returns cycles from accept edge to out_valid
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        output logic [31:0] r, output logic d, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    r = result; d = div_by_zero;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] va [6] = '{32'h40C00000, 32'hBF800000, 32'h40A00000, 32'h00000000, 32'h7F000000, 32'h00800000};
    logic [31:0] vb [6] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3E800000, 32'h7F000000};
    logic [31:0] vr [6] = '{32'h40400000, 32'hBEAAAAAA, 32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
    logic        vd [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int          vl [6] = '{26, 26, 0, 0, 26, 26};
    logic [31:0] r;
    logic d;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], r, d, lat);
      checks++; if (r !== vr[i]) begin errors++; $display("FAIL directed_result[%0d]: got %h expected %h", i, r, vr[i]); end
      checks++; if (d !== vd[i]) begin errors++; $display("FAIL directed_dbz[%0d]: got %b expected %b", i, d, vd[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, vl[i]); end
      release_out();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL directed_return_idle[%0d]: got out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_special();
    logic [31:0] sa [8] = '{32'h7F800000, 32'h7FC12345, 32'hFF800000, 32'h00000000, 32'h40400000, 32'h7F800000, 32'h00400000, 32'h3F800000};
    logic [31:0] sb [8] = '{32'hFF800000, 32'h3F800000, 32'h00000000, 32'h7F800000, 32'hFF800000, 32'hC0400000, 32'h40000000, 32'h7F812345};
    logic [31:0] r, er;
    logic d, ed;
    int lat, el;
    for (int i = 0; i < 8; i++) begin
      ref_div(sa[i], sb[i], er, ed, el);
      run_op(sa[i], sb[i], r, d, lat);
      checks++; if (r !== er) begin errors++; $display("FAIL special_result[%0d]: got %h expected %h", i, r, er); end
      checks++; if (d !== ed) begin errors++; $display("FAIL special_dbz[%0d]: got %b expected %b", i, d, ed); end
      checks++; if (lat !== el) begin errors++; $display("FAIL special_latency[%0d]: got %0d expected %0d", i, lat, el); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic d;
    int lat;
    run_op(32'h40C00000, 32'h40000000, r, d, lat);
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h40400000) begin
        errors++; $display("FAIL backpressure_hold[%0d]: got out_valid=%b in_ready=%b result=%h expected 1/0/40400000", i, out_valid, in_ready, result);
      end
    end
    in_valid = 1'b0;
    release_out();
    run_op(32'hBF800000, 32'h40400000, r, d, lat);
    checks++; if (r !== 32'hBEAAAAAA || lat !== 26) begin errors++; $display("FAIL backpressure_next_op: got %h lat %0d expected beaaaaaa lat 26", r, lat); end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic d;
    int lat;
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midreset_busy: got out_valid=%b in_ready=%b expected 0/0", out_valid, in_ready); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got in_ready=%b out_valid=%b result=%h dbz=%b expected 1/0/00000000/0", in_ready, out_valid, result, div_by_zero);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(32'h40C00000, 32'h40000000, r, d, lat);
    checks++; if (r !== 32'h40400000 || lat !== 26) begin errors++; $display("FAIL midreset_recover: got %h lat %0d expected 40400000 lat 26", r, lat); end
    release_out();
  endtask

  task automatic test_random();
    logic [31:0] x, y, r, er;
    logic d, ed;
    int lat, el;
    for (int i = 0; i < 300; i++) begin
      x = rand_fp();
      y = rand_fp();
      ref_div(x, y, er, ed, el);
      run_op(x, y, r, d, lat);
      checks++; if (r !== er) begin errors++; $display("FAIL random_result: %h/%h got %h expected %h", x, y, r, er); end
      checks++; if (d !== ed) begin errors++; $display("FAIL random_dbz: %h/%h got %b expected %b", x, y, d, ed); end
      checks++; if (lat !== el) begin errors++; $display("FAIL random_latency: %h/%h got %0d expected %0d", x, y, lat, el); end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
